// File: rtl/ceres_param.sv
// ceres_param: shared definitions for the instruction aligner.
//   align_state_e - aligner buffer state (EMPTY, SKIP, UPPER)
//   INSTR_UNCOMP  - low two bits marking a 32-bit (uncompressed) instruction
package ceres_param;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SKIP  = 2'd1,
    UPPER = 2'd2
  } align_state_e;

  localparam logic [1:0] INSTR_UNCOMP = 2'b11;

endpackage

// File: rtl/instr_aligner_perf.sv
// instr_aligner_perf: free-running wrapping event counters for the aligner.
// Only built when CERES_ALIGN_PERF_EN is defined.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   fire_i           - an instruction left the aligner (output handshake)
//   rvc_i            - the departing instruction is compressed
//   split_i          - the departing instruction straddled two fetch words
//   perf_rvc_cnt_o   - count of compressed instructions emitted
//   perf_split_cnt_o - count of split instructions emitted
module instr_aligner_perf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fire_i,
  input  logic        rvc_i,
  input  logic        split_i,
  output logic [31:0] perf_rvc_cnt_o,
  output logic [31:0] perf_split_cnt_o
);

  logic [31:0] r_rvc_cnt;
  logic [31:0] r_split_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvc_cnt   <= '0;
      r_split_cnt <= '0;
    end else if (fire_i) begin
      if (rvc_i)   r_rvc_cnt   <= r_rvc_cnt + 32'd1;
      if (split_i) r_split_cnt <= r_split_cnt + 32'd1;
    end
  end

  assign perf_rvc_cnt_o   = r_rvc_cnt;
  assign perf_split_cnt_o = r_split_cnt;

endmodule

// File: rtl/instr_aligner.sv
// instr_aligner: turns a stream of word-aligned 32-bit fetch words into a
// stream of 16/32-bit instructions (RVC alignment), one per cycle.
// Optional macro: CERES_ALIGN_PERF_EN adds perf_rvc_cnt_o / perf_split_cnt_o.
// Ports:
//   clk_i, rst_ni         - clock, asynchronous active-low reset
//   flush_i, redirect_pc_i- discard state and restart at redirect_pc_i
//   fetch_*               - word input (valid/ready handshake, data, pc, err)
//   instr_*               - registered instruction output (valid/ready)
//   is_compressed_o       - output instruction is 16-bit
module instr_aligner
  import ceres_param::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  output logic        is_compressed_o
`ifdef CERES_ALIGN_PERF_EN
  ,
  output logic [31:0] perf_rvc_cnt_o,
  output logic [31:0] perf_split_cnt_o
`endif
);

  align_state_e r_state;
  logic [15:0]  r_hold;
  logic [31:0]  r_hold_pc;
  logic         r_hold_err;

  logic         r_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc;
  logic         r_err;
  logic         r_cmp;

  logic         w_slot_free;
  logic         w_hold_rvc;
  logic         w_take_word;
  logic         w_fetch_fire;

  logic         w_emit;
  logic [31:0]  w_emit_instr;
  logic [31:0]  w_emit_pc;
  logic         w_emit_err;
  logic         w_load;
  align_state_e w_next_state;

  assign w_slot_free  = !r_valid || instr_ready_i;
  assign w_hold_rvc   = (r_hold[1:0] != INSTR_UNCOMP);
  assign w_take_word  = (r_state == EMPTY) || (r_state == SKIP) ||
                        ((r_state == UPPER) && !w_hold_rvc);
  assign fetch_ready_o = w_slot_free && w_take_word && !flush_i;
  assign w_fetch_fire  = fetch_valid_i && fetch_ready_o;

  always_comb begin
    w_emit       = 1'b0;
    w_emit_instr = '0;
    w_emit_pc    = '0;
    w_emit_err   = 1'b0;
    w_load       = 1'b0;
    w_next_state = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_fetch_fire) begin
          w_emit     = 1'b1;
          w_emit_pc  = fetch_pc_i;
          w_emit_err = fetch_err_i;
          if (fetch_data_i[1:0] != INSTR_UNCOMP) begin
            w_emit_instr = {16'h0000, fetch_data_i[15:0]};
            w_load       = 1'b1;
            w_next_state = UPPER;
          end else begin
            w_emit_instr = fetch_data_i;
          end
        end
      end
      SKIP: begin
        if (w_fetch_fire) begin
          w_load       = 1'b1;
          w_next_state = UPPER;
        end
      end
      UPPER: begin
        if (w_hold_rvc) begin
          w_emit       = 1'b1;
          w_emit_instr = {16'h0000, r_hold};
          w_emit_pc    = r_hold_pc;
          w_emit_err   = r_hold_err;
          w_next_state = EMPTY;
        end else if (w_fetch_fire) begin
          w_emit       = 1'b1;
          w_emit_instr = {fetch_data_i[15:0], r_hold};
          w_emit_pc    = r_hold_pc;
          w_emit_err   = r_hold_err | fetch_err_i;
          w_load       = 1'b1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

`ifdef CERES_ALIGN_PERF_EN
  logic r_split;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= EMPTY;
      r_hold     <= '0;
      r_hold_pc  <= '0;
      r_hold_err <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_err      <= 1'b0;
      r_cmp      <= 1'b0;
`ifdef CERES_ALIGN_PERF_EN
      r_split    <= 1'b0;
`endif
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_state    <= redirect_pc_i[1] ? SKIP : EMPTY;
      r_hold     <= '0;
      // Restart PC parked in hold_pc; the first accepted word overwrites it.
      r_hold_pc  <= redirect_pc_i;
      r_hold_err <= 1'b0;
    end else if (w_slot_free) begin
      r_valid <= w_emit;
      r_state <= w_next_state;
      if (w_emit) begin
        r_instr <= w_emit_instr;
        r_pc    <= w_emit_pc;
        r_err   <= w_emit_err;
        r_cmp   <= (w_emit_instr[1:0] != INSTR_UNCOMP);
`ifdef CERES_ALIGN_PERF_EN
        r_split <= (r_state == UPPER) && !w_hold_rvc;
`endif
      end
      if (w_load) begin
        r_hold     <= fetch_data_i[31:16];
        r_hold_pc  <= fetch_pc_i + 32'd2;
        r_hold_err <= fetch_err_i;
      end
    end
  end

  assign instr_valid_o   = r_valid;
  assign instr_o         = r_instr;
  assign instr_pc_o      = r_pc;
  assign instr_err_o     = r_err;
  assign is_compressed_o = r_cmp;

`ifdef CERES_ALIGN_PERF_EN
  logic w_out_fire;
  assign w_out_fire = r_valid && instr_ready_i && !flush_i;

  instr_aligner_perf u_perf (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fire_i           (w_out_fire),
    .rvc_i            (r_cmp),
    .split_i          (r_split),
    .perf_rvc_cnt_o   (perf_rvc_cnt_o),
    .perf_split_cnt_o (perf_split_cnt_o)
  );
`endif

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        fetch_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        is_cmp;
`ifdef CERES_ALIGN_PERF_EN
  logic [31:0] perf_rvc;
  logic [31:0] perf_split;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  instr_aligner dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .redirect_pc_i   (redirect_pc),
    .fetch_valid_i   (fetch_valid),
    .fetch_ready_o   (fetch_ready),
    .fetch_data_i    (fetch_data),
    .fetch_pc_i      (fetch_pc),
    .fetch_err_i     (fetch_err),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_err_o     (instr_err),
    .is_compressed_o (is_cmp)
`ifdef CERES_ALIGN_PERF_EN
    ,
    .perf_rvc_cnt_o   (perf_rvc),
    .perf_split_cnt_o (perf_split)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [31:0] pc, input logic e);
    fetch_valid = 1'b1;
    fetch_data  = d;
    fetch_pc    = pc;
    fetch_err   = e;
  endtask

  task automatic idle;
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i, input logic [31:0] pc,
                         input logic e, input logic c);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".instr"}, instr, i);
    chk({tag, ".pc"},    instr_pc, pc);
    chk({tag, ".err"},   {31'd0, instr_err}, {31'd0, e});
    chk({tag, ".cmp"},   {31'd0, is_cmp}, {31'd0, c});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".idle"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0; fetch_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.pc",    instr_pc, 32'd0);
    chk("rst.err",   {31'd0, instr_err}, 32'd0);
    chk("rst.cmp",   {31'd0, is_cmp}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("rst.fready", {31'd0, fetch_ready}, 32'd1);

    // 32-bit word
    put(32'h00000013, 32'h1000, 1'b0); tick; idle;
    chk_out("w32", 32'h00000013, 32'h1000, 1'b0, 1'b0);
    tick; chk_idle("w32");

    // two compressed halves in one word
    put(32'h00014501, 32'h2000, 1'b0); tick; idle;
    chk_out("c2a", 32'h00004501, 32'h2000, 1'b0, 1'b1);
    chk("c2a.fready", {31'd0, fetch_ready}, 32'd0);
    tick;
    chk_out("c2b", 32'h00000001, 32'h2002, 1'b0, 1'b1);
    tick; chk_idle("c2");

    // split 32-bit instruction across words
    put(32'h00134501, 32'h3000, 1'b0); tick; idle;
    chk_out("spa", 32'h00004501, 32'h3000, 1'b0, 1'b1);
    chk("spa.fready", {31'd0, fetch_ready}, 32'd1);
    put(32'h45010000, 32'h3004, 1'b0); tick; idle;
    chk_out("spb", 32'h00000013, 32'h3002, 1'b0, 1'b0);
    tick;
    chk_out("spc", 32'h00004501, 32'h3006, 1'b0, 1'b1);
    tick; chk_idle("sp");

    // redirect into upper half
    flush = 1'b1; redirect_pc = 32'h4002; tick; flush = 1'b0;
    chk_idle("rd0");
    put(32'h00010013, 32'h4000, 1'b0); tick; idle;
    chk_idle("rd1");
    tick;
    chk_out("rd", 32'h00000001, 32'h4002, 1'b0, 1'b1);
    tick; chk_idle("rd2");

    // backpressure
    instr_ready = 1'b0;
    put(32'h00000013, 32'h6000, 1'b0); tick;
    put(32'h00000093, 32'h6004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_out("bp", 32'h00000013, 32'h6000, 1'b0, 1'b0);
      chk("bp.fready", {31'd0, fetch_ready}, 32'd0);
      tick;
    end
    chk_out("bp3", 32'h00000013, 32'h6000, 1'b0, 1'b0);
    instr_ready = 1'b1;
    #1;
    chk("bp.fready1", {31'd0, fetch_ready}, 32'd1);
    tick; idle;
    chk_out("bpn", 32'h00000093, 32'h6004, 1'b0, 1'b0);
    tick; chk_idle("bp");

    // flush with split pending
    put(32'h00134501, 32'h7000, 1'b0); tick; idle;
    chk_out("fl0", 32'h00004501, 32'h7000, 1'b0, 1'b1);
    flush = 1'b1; redirect_pc = 32'h5000; tick; flush = 1'b0;
    chk_idle("fl1");
    tick; chk_idle("fl2");
    put(32'h00000013, 32'h5000, 1'b0); tick; idle;
    chk_out("fl", 32'h00000013, 32'h5000, 1'b0, 1'b0);
    tick; chk_idle("fl3");

    // PC wrap at top of address space
    put(32'h00010001, 32'hFFFFFFFC, 1'b0); tick; idle;
    chk_out("wr0", 32'h00000001, 32'hFFFFFFFC, 1'b0, 1'b1);
    tick;
    chk_out("wr1", 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1);
    tick; chk_idle("wr");

    // error propagation through hold
    put(32'h00134501, 32'h8000, 1'b1); tick; idle;
    chk_out("er0", 32'h00004501, 32'h8000, 1'b1, 1'b1);
    put(32'h00010000, 32'h8004, 1'b0); tick; idle;
    chk_out("er1", 32'h00000013, 32'h8002, 1'b1, 1'b0);
    tick;
    chk_out("er2", 32'h00000001, 32'h8006, 1'b0, 1'b1);
    tick; chk_idle("er");

`ifdef CERES_ALIGN_PERF_EN
    chk("perf.rvc",   perf_rvc,   32'd9);
    chk("perf.split", perf_split, 32'd2);
`endif

    // reset mid-split discards hold
    put(32'h00134501, 32'h9000, 1'b0); tick; idle;
    chk_out("rs0", 32'h00004501, 32'h9000, 1'b0, 1'b1);
    rst_n = 1'b0; #1;
    chk("rs.valid", {31'd0, instr_valid}, 32'd0);
    chk("rs.instr", instr, 32'd0);
    tick; rst_n = 1'b1; tick;
    chk_idle("rs1");
    chk("rs.fready", {31'd0, fetch_ready}, 32'd1);
    put(32'h00000093, 32'hA000, 1'b0); tick; idle;
    chk_out("rs2", 32'h00000093, 32'hA000, 1'b0, 1'b0);
    tick; chk_idle("rs3");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, listed first as: clk_i input 1, rising-edge clock; rst_ni input 1, asynchronous active-low reset.
REQ-002 The module SHALL have the following ports: flush_i input 1, discard all buffered and output state.
REQ-003 The module SHALL have the following ports: redirect_pc_i input 32, restart PC, valid with flush_i; bit1 selects the starting halfword.
REQ-004 The module SHALL have the following ports: fetch_valid_i input 1, fetch_ready_o output 1, fetch_data_i input 32, fetch_pc_i input 32 (word-aligned), fetch_err_i input 1 (word fetch fault).
REQ-005 The module SHALL have the following ports: instr_valid_o output 1, instr_ready_i input 1, instr_o output 32 (raw instruction, upper 16 bits zero when compressed), instr_pc_o output 32, instr_err_o output 1, is_compressed_o output 1.

Function
REQ-006 The module SHALL transfer a word on fetch_valid_i && fetch_ready_o, and an instruction on instr_valid_o && instr_ready_i.
REQ-007 The module SHALL register all outputs, giving a latency of one cycle from the accepting edge to instr_valid_o; the output slot is free when !instr_valid_o || instr_ready_i.
REQ-008 The module SHALL hold instr_o, instr_pc_o, instr_err_o and is_compressed_o stable while instr_valid_o=1 && instr_ready_i=0.
REQ-009 The module SHALL implement states EMPTY (nothing buffered), SKIP (discard lower half of next word), and UPPER (16-bit hold = data[31:16], hold_pc = word_pc+2, hold_err).
REQ-010 In EMPTY, when a word is accepted with data[1:0]!=2'b11, the module SHALL emit {16'h0,data[15:0]} at fetch_pc_i and go to UPPER.
REQ-011 In EMPTY, when a word is accepted with data[1:0]==2'b11, the module SHALL emit the full word and stay in EMPTY.
REQ-012 In SKIP, an accepted word SHALL load the hold with nothing emitted, and the state SHALL go to UPPER.
REQ-013 In UPPER with hold[1:0]!=2'b11, the module SHALL emit {16'h0,hold} at hold_pc without accepting a word (fetch_ready_o=0), then go to EMPTY.
REQ-014 In UPPER with hold[1:0]==2'b11, an accepted word SHALL emit {data[15:0],hold} at hold_pc with err = hold_err|fetch_err_i, reload the hold from data[31:16], and stay in UPPER.
REQ-015 fetch_ready_o SHALL equal slot_free && (EMPTY || SKIP || (UPPER && hold[1:0]==2'b11)) && !flush_i.
REQ-016 is_compressed_o SHALL equal (instr_o[1:0]!=2'b11) for every valid output.
REQ-017 flush_i SHALL have the highest priority and act synchronously: in the same cycle instr_valid_o is cleared at the next edge, any output handshake is void, no word is accepted, and the state becomes SKIP if redirect_pc_i[1]=1, otherwise EMPTY.
REQ-018 A flush with a split instruction pending SHALL produce no partial output.
REQ-019 PC arithmetic SHALL be 32-bit modulo; hold_pc for a word at 0xFFFFFFFC SHALL be 0xFFFFFFFE.
REQ-020 In SKIP, the module SHALL accept a word at redirect_pc_i & ~3; a mismatch is not checked.

Reset
REQ-021 On reset: state=EMPTY, instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_err_o=0, is_compressed_o=0, hold=0, hold_pc=0, hold_err=0; fetch_ready_o is 1 after reset release.
REQ-022 Reset assertion mid-split SHALL discard the hold with no output.

Configuration
REQ-023 The macro CERES_ALIGN_PERF_EN, when defined, SHALL add perf_rvc_cnt_o (output 32) and perf_split_cnt_o (output 32): free-running wrapping counts of emitted compressed and split instructions, counted on the output handshake, reset to 0, and not cleared by flush.
REQ-024 When CERES_ALIGN_PERF_EN is undefined, these ports and counters SHALL be absent and the module SHALL be otherwise identical.

Structure
REQ-025 The state enum align_state_e (EMPTY, SKIP, UPPER) and the constant for the uncompressed marker 2'b11 SHALL reside in ceres_param.
REQ-026 The counters SHALL be in the sub-module instr_aligner_perf, instantiated only under CERES_ALIGN_PERF_EN; the datapath SHALL be a single module.

Verification
REQ-027 Reset, then word 0x00000013 @0x1000 -> instr_o=0x00000013, pc=0x1000, is_compressed_o=0, one cycle later.
REQ-028 Word 0x00014501 @0x2000 -> 0x00004501@0x2000, then 0x00000001@0x2002 on consecutive cycles; fetch_ready_o=0 during the second emission.
REQ-029 Words 0x00134501 @0x3000, 0x45010000 @0x3004 -> 0x00004501@0x3000, 0x00000013@0x3002, 0x00004501@0x3006.
REQ-030 flush_i with redirect_pc_i=0x4002, then word 0x00010013 @0x4000 -> only 0x00000001@0x4002 is emitted.
REQ-031 instr_ready_i held 0 for 3 cycles with valid output -> outputs stable and fetch_ready_o=0 throughout; the next instruction follows the cycle after ready.
REQ-032 Split pending (hold 0x0013) then flush_i with redirect_pc_i=0x5000 -> no output; the next word 0x00000013 @0x5000 is emitted alone; with perf enabled, split count is unchanged.
